hilo_mdu: RTL and testbench

Multi-cycle multiply/divide unit that owns the HI/LO register pair. It sits in the execute stage beside the ALU and consumes the MulOp, MTHILO and MFHILO encodings produced by the decoder. Latencies and datapath width are parametrised, and it drives a busy/stall handshake back to the pipeline hazard logic. It adds real sequencing, kill and divide-corner behaviour on top of the single-cycle decode.

---
 rtl/hilo_mdu_pkg.sv | 44 ++++
 rtl/hilo_mdu_core.sv | 82 ++++++++
 rtl/hilo_mdu.sv | 153 +++++++++++++++
 tb/tb_hilo_mdu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
// The instruction decoder imports the same MulOp/MTHILO/MFHILO constants.
package hilo_mdu_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;
    localparam int COUNT_W             = 6;

    typedef enum logic [2:0] {
        MUL_MULTU = 3'b000,
        MUL_MULT  = 3'b001,
        MUL_DIVU  = 3'b010,
        MUL_DIV   = 3'b011,
        MUL_NONE  = 3'b100,
        MUL_MADDU = 3'b101,
        MUL_MADD  = 3'b110,
        MUL_RSVD  = 3'b111
    } mul_op_e;

    typedef enum logic [1:0] {
        MT_LO   = 2'b00,
        MT_HI   = 2'b01,
        MT_NONE = 2'b10,
        MT_RSVD = 2'b11
    } mthilo_e;

    typedef enum logic [1:0] {
        MF_NONE = 2'b00,
        MF_LO   = 2'b01,
        MF_HI   = 2'b10,
        MF_RSVD = 2'b11
    } mfhilo_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_div_op(input mul_op_e op);
        return (op == MUL_DIVU) || (op == MUL_DIV);
    endfunction

endpackage

// File: rtl/hilo_mdu_core.sv
// Combinational {HI,LO} result for a latched multiply/divide op.
// MADD/MADDU accumulate only when HILO_MDU_MADD_EN is defined.
module hilo_mdu_core
    import hilo_mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  mul_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 signed_mul;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   prod;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     q_mag;
    logic [WIDTH-1:0]     r_mag;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both
    // signed and unsigned products (two's complement, modulo 2^(2*WIDTH)).
    always_comb begin
        signed_mul = (op == MUL_MULT) || (op == MUL_MADD);
        a_ext      = signed_mul ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext      = signed_mul ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod       = a_ext * b_ext;
    end

    // Signed divide runs on magnitudes; quotient and remainder signs fixed after.
    always_comb begin
        a_neg = (op == MUL_DIV) && a[WIDTH-1];
        b_neg = (op == MUL_DIV) && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        hi_out = hi_in;
        lo_out = lo_in;
        case (op)
            MUL_MULTU, MUL_MULT: begin
                {hi_out, lo_out} = prod;
            end
`ifdef HILO_MDU_MADD_EN
            MUL_MADDU, MUL_MADD: begin
                {hi_out, lo_out} = {hi_in, lo_in} + prod;
            end
`endif
            MUL_DIVU, MUL_DIV: begin
                if (b == '0) begin
                    lo_out = '1;
                    hi_out = a;
                end else if ((op == MUL_DIV) && (a == MIN_VAL) && (b == '1)) begin
                    lo_out = MIN_VAL;
                    hi_out = '0;
                end else begin
                    lo_out = (a_neg ^ b_neg) ? -q_mag : q_mag;
                    hi_out = a_neg ? -r_mag : r_mag;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair, with busy/stall handshake.
// Define HILO_MDU_MADD_EN to enable MADDU (101) and MADD (110).
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mul_op,
    input  logic [1:0]       mthilo,
    input  logic [1:0]       mfhilo,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    mul_op_e              op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    mul_op_e              op_in;
    mthilo_e              mt_in;
    mfhilo_e              mf_in;
    logic                 op_valid;
    logic                 accept;
    logic                 mt_we;
    logic [WIDTH-1:0]     core_hi;
    logic [WIDTH-1:0]     core_lo;

    assign op_in = mul_op_e'(mul_op);
    assign mt_in = mthilo_e'(mthilo);
    assign mf_in = mfhilo_e'(mfhilo);

    always_comb begin
        op_valid = 1'b0;
        case (op_in)
            MUL_MULTU, MUL_MULT, MUL_DIVU, MUL_DIV: op_valid = 1'b1;
`ifdef HILO_MDU_MADD_EN
            MUL_MADDU, MUL_MADD:                    op_valid = 1'b1;
`endif
            default:                                op_valid = 1'b0;
        endcase
    end

    assign busy   = (state_q == ST_RUN);
    assign accept = start && op_valid && !busy && !flush;
    assign mt_we  = start && !busy && !flush && ((mt_in == MT_LO) || (mt_in == MT_HI));
    // Any HI/LO-touching request must wait while an op is in flight.
    assign stall  = start && busy &&
                    ((op_in != MUL_NONE) || (mt_in != MT_NONE) || (mf_in != MF_NONE));

    hilo_mdu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_in  (hi_q),
        .lo_in  (lo_q),
        .hi_out (core_hi),
        .lo_out (core_lo)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (mt_we) begin
                    if (mt_in == MT_HI) hi_d = rs_data;
                    else                lo_d = rs_data;
                end
                if (accept) begin
                    state_d = ST_RUN;
                    count_d = is_div_op(op_in) ? COUNT_W'(DIV_CYCLES) : COUNT_W'(MULT_CYCLES);
                    op_d    = op_in;
                    a_d     = rs_data;
                    b_d     = rt_data;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q == COUNT_W'(1)) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    hi_d    = core_hi;
                    lo_d    = core_lo;
                end else begin
                    count_d = count_q - COUNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: operand latches need no reset; they are only consumed after an accept loads them.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        rd_data = '0;
        case (mf_in)
            MF_LO:   rd_data = lo_q;
            MF_HI:   rd_data = hi_q;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu; MADD vectors run when HILO_MDU_MADD_EN is defined.
module tb_hilo_mdu;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   mul_op;
    logic [1:0]   mthilo;
    logic [1:0]   mfhilo;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         flush;
    logic         busy;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hilo_mdu #(
        .WIDTH       (W),
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mul_op  (mul_op),
        .mthilo  (mthilo),
        .mfhilo  (mfhilo),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        start  = 1'b0;
        mul_op = 3'b100;
        mthilo = 2'b10;
        mfhilo = 2'b00;
        flush  = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        mul_op  = op;
        rs_data = a;
        rt_data = b;
        tick;
        idle_in;
    endtask

    task automatic mt_write(input logic [1:0] sel, input logic [W-1:0] val);
        start   = 1'b1;
        mthilo  = sel;
        rs_data = val;
        tick;
        idle_in;
    endtask

    // Issues an op, counts busy cycles (bounded) and checks the final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_cycles,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        issue(op, a, b);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 100) begin
            tick;
            n++;
        end
        check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        idle_in;
        rs_data = '0;
        rt_data = '0;
        reset   = 1'b0;
        tick;
        tick;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_rd", 64'(rd_data), 64'd0);
        reset = 1'b1;
        tick;

        // Multiply and divide vectors, issued back to back.
        run_op("mult_neg", 3'b001, 32'hFFFF_FFFE, 32'd3, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 3'b011, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negdivisor", 3'b011, 32'd7, 32'hFFFF_FFFE, ND, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_7_2", 3'b010, 32'd7, 32'd2, ND, 32'd1, 32'd3);
        run_op("divu_big", 3'b010, 32'hFFFF_FFFF, 32'd2, ND, 32'd1, 32'h7FFF_FFFF);
        run_op("div_by0", 3'b011, 32'd5, 32'd0, ND, 32'd5, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'd0, 32'h8000_0000);

        // MT writes while idle.
        mt_write(2'b01, 32'h1234_5678);
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(lo), 64'h8000_0000);
        mt_write(2'b00, 32'hCAFE_0001);
        check("mtlo_lo", 64'(lo), 64'hCAFE_0001);
        check("mtlo_hi_kept", 64'(hi), 64'h1234_5678);

        // MT and MF in the same cycle: read returns the old value.
        start   = 1'b1;
        mthilo  = 2'b01;
        mfhilo  = 2'b10;
        rs_data = 32'h0000_AAAA;
        #1;
        check("mtmf_rd_old", 64'(rd_data), 64'h1234_5678);
        tick;
        check("mtmf_rd_new", 64'(rd_data), 64'h0000_AAAA);
        idle_in;
        check("mtmf_hi", 64'(hi), 64'h0000_AAAA);

        // MFHI issued at busy cycle 2 of a MULT stalls until busy falls.
        issue(3'b001, 32'h0001_0000, 32'h0003_0000);
        tick;
        start  = 1'b1;
        mfhilo = 2'b10;
        #1;
        check("mf_stall_on", 64'(stall), 64'd1);
        n = 0;
        while (stall && n < 50) begin
            n++;
            tick;
        end
        check("mf_stall_cycles", 64'(n), 64'd4);
        check("mf_busy_off", 64'(busy), 64'd0);
        check("mf_rd_newhi", 64'(rd_data), 64'd3);
        tick;
        idle_in;
        check("mf_lo", 64'(lo), 64'd0);

        // MTLO while busy stalls, then lands after the multiply result.
        issue(3'b000, 32'd2, 32'd3);
        start = 1'b1;
        #1;
        check("none_nostall", 64'(stall), 64'd0);
        mthilo  = 2'b00;
        rs_data = 32'hDEAD_BEEF;
        #1;
        check("mt_stall_on", 64'(stall), 64'd1);
        n = 0;
        while (stall && n < 50) begin
            n++;
            tick;
        end
        check("mt_stall_cycles", 64'(n), 64'd5);
        check("mt_lo_mulres", 64'(lo), 64'd6);
        tick;
        idle_in;
        check("mt_lo_written", 64'(lo), 64'hDEAD_BEEF);
        check("mt_hi_mulres", 64'(hi), 64'd0);

        // Flush at RUN cycle 3 leaves HI/LO untouched.
        mt_write(2'b01, 32'h0000_0055);
        issue(3'b001, 32'h0001_0000, 32'h0003_0000);
        tick;
        tick;
        flush = 1'b1;
        #1;
        check("flush_busy_before", 64'(busy), 64'd1);
        tick;
        flush = 1'b0;
        check("flush_busy_after", 64'(busy), 64'd0);
        repeat (6) tick;
        check("flush_hi", 64'(hi), 64'h55);
        check("flush_lo", 64'(lo), 64'hDEAD_BEEF);

        // Flush beats a same-cycle start and MT write.
        start  = 1'b1;
        mul_op = 3'b001;
        flush  = 1'b1;
        tick;
        idle_in;
        check("flush_start_busy", 64'(busy), 64'd0);
        start   = 1'b1;
        mthilo  = 2'b01;
        rs_data = 32'h0000_0BAD;
        flush   = 1'b1;
        tick;
        idle_in;
        check("flush_mt_hi", 64'(hi), 64'h55);

        // Reset mid-divide clears everything and no late write follows.
        issue(3'b011, 32'd100, 32'd7);
        tick;
        tick;
        reset = 1'b0;
        tick;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_hi", 64'(hi), 64'd0);
        check("rstmid_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        repeat (12) tick;
        check("rstmid_hi_late", 64'(hi), 64'd0);
        check("rstmid_busy_late", 64'(busy), 64'd0);

        // Reserved op 111 never starts anything.
        issue(3'b111, 32'd1, 32'd1);
        check("op111_busy", 64'(busy), 64'd0);

`ifdef HILO_MDU_MADD_EN
        mt_write(2'b01, 32'd0);
        mt_write(2'b00, 32'hFFFF_FFFF);
        run_op("maddu_carry", 3'b101, 32'd1, 32'd1, NM, 32'd1, 32'd0);
        run_op("madd_neg", 3'b110, 32'hFFFF_FFFF, 32'd1, NM, 32'd0, 32'hFFFF_FFFF);
`else
        issue(3'b101, 32'd1, 32'd1);
        check("op101_busy", 64'(busy), 64'd0);
        issue(3'b110, 32'd1, 32'd1);
        check("op110_busy", 64'(busy), 64'd0);
        check("op110_lo", 64'(lo), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
